// File: rtl/counter_pkg.sv
// Shared definitions for the up-counter and its passive checker.
//   CNT_WIDTH : default width of the counter value bus
//   state_t   : checker FSM states
package counter_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        RESYNC  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : synchronous reset, clears the count
//   i_inc   : add one this cycle (ignored once the count is all-ones)
//   o_count : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_checker.sv
// Passive checker for a free-running up-counter. Learns the sequence, then
// requires each sample to equal the previous sample + 1 (mod 2^WIDTH).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing seen since reset; first sample seeds expected
// ACQUIRE | counting consecutive correct increments towards lock
// LOCKED  | sequence trusted; a wrong sample is a counted mismatch
// RESYNC  | re-acquiring after a mismatch; further errors not counted
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   value       : observed counter output
//   valid       : value is a sample this cycle
//   obs_reset   : observed counter is in reset, next expected value is 0
//   locked      : state is LOCKED
//   mismatch    : one-cycle pulse, wrong sample while LOCKED
//   wrap        : one-cycle pulse, correct all-ones sample while LOCKED
//   err_count   : saturating count of mismatches
//   expected    : value the next sample must equal
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH     = CNT_WIDTH,
    parameter int LOCK_LEN  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     value,
    input  logic                 valid,
    input  logic                 obs_reset,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam logic [7:0] LP_LOCK_LEN = 8'(LOCK_LEN);

    state_t           r_state;
    logic [7:0]       r_run;
    logic [WIDTH-1:0] r_expected;
    logic             r_locked;
    logic             r_mismatch;
    logic             r_wrap;

    state_t           w_state_nxt;
    logic [7:0]       w_run_nxt;
    logic [WIDTH-1:0] w_expected_nxt;
    logic             w_mismatch_nxt;
    logic             w_wrap_nxt;
    logic [7:0]       w_run_inc;
    logic [WIDTH-1:0] w_reseed;
    logic             w_hit;

    assign w_run_inc = r_run + 8'd1;
    assign w_reseed  = value + WIDTH'(1);
    assign w_hit     = (value == r_expected);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_run      <= '0;
            r_expected <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= w_run_nxt;
            r_expected <= w_expected_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
            r_mismatch <= w_mismatch_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_expected_nxt = r_expected;
        w_mismatch_nxt = 1'b0;
        w_wrap_nxt     = 1'b0;

        // Observed counter in reset: it will restart at 0, lock is kept.
        if (obs_reset) begin
            w_expected_nxt = '0;
            w_run_nxt      = '0;
            if (r_state == IDLE) begin
                w_state_nxt = ACQUIRE;
            end
        end else if (valid) begin
            unique case (r_state)
                IDLE: begin
                    w_expected_nxt = w_reseed;
                    w_run_nxt      = '0;
                    w_state_nxt    = ACQUIRE;
                end
                ACQUIRE, RESYNC: begin
                    if (w_hit) begin
                        w_run_nxt      = w_run_inc;
                        w_expected_nxt = r_expected + WIDTH'(1);
                        if (w_run_inc >= LP_LOCK_LEN) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_expected_nxt = w_reseed;
                        w_run_nxt      = '0;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_expected_nxt = r_expected + WIDTH'(1);
                        w_wrap_nxt     = &value;
                    end else begin
                        w_mismatch_nxt = 1'b1;
                        w_expected_nxt = w_reseed;
                        w_run_nxt      = '0;
                        w_state_nxt    = RESYNC;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Counted on the same edge the mismatch pulse is registered.
    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_mismatch_nxt),
        .o_count (err_count)
    );

    assign locked   = r_locked;
    assign mismatch = r_mismatch;
    assign wrap     = r_wrap;
    assign expected = r_expected;

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       valid;
    logic       obs_reset;

    logic        locked_a, mismatch_a, wrap_a;
    logic [15:0] err_a;
    logic [7:0]  expected_a;

    logic        locked_b, mismatch_b, wrap_b;
    logic [1:0]  err_b;
    logic [7:0]  expected_b;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(8), .LOCK_LEN(4), .ERR_CNT_W(16)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .valid     (valid),
        .obs_reset (obs_reset),
        .locked    (locked_a),
        .mismatch  (mismatch_a),
        .wrap      (wrap_a),
        .err_count (err_a),
        .expected  (expected_a)
    );

    counter_checker #(.WIDTH(8), .LOCK_LEN(1), .ERR_CNT_W(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .valid     (valid),
        .obs_reset (obs_reset),
        .locked    (locked_b),
        .mismatch  (mismatch_b),
        .wrap      (wrap_b),
        .err_count (err_b),
        .expected  (expected_b)
    );

    typedef struct packed {
        logic        sel;
        logic        l;
        logic        m;
        logic        w;
        logic [15:0] e;
        logic [7:0]  x;
    } resp_t;

    resp_t sb_q[$];
    int    id_q[$];
    int    total = 0;
    int    bad   = 0;
    int    step_id = 0;

    task automatic step(input logic sel, input logic rst, input logic obs,
                        input logic vld, input logic [7:0] val,
                        input logic l, input logic m, input logic w,
                        input logic [15:0] e, input logic [7:0] x);
        resp_t r;
        @(negedge clk);
        reset     = rst;
        obs_reset = obs;
        valid     = vld;
        value     = val;
        r.sel = sel; r.l = l; r.m = m; r.w = w; r.e = e; r.x = x;
        sb_q.push_back(r);
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Monitor: every response is registered, so it is visible just after the edge.
    initial begin
        resp_t exp_r, act;
        int    id;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_r = sb_q.pop_front();
                id    = id_q.pop_front();
                if (exp_r.sel)
                    act = {1'b1, locked_b, mismatch_b, wrap_b, {14'd0, err_b}, expected_b};
                else
                    act = {1'b0, locked_a, mismatch_a, wrap_a, err_a, expected_a};
                total++;
                if (act !== exp_r) begin
                    bad++;
                    $display("FAIL step%0d dut%0d: got l=%b m=%b w=%b err=%0d exp=%h, want l=%b m=%b w=%b err=%0d exp=%h",
                             id, exp_r.sel, act.l, act.m, act.w, act.e, act.x,
                             exp_r.l, exp_r.m, exp_r.w, exp_r.e, exp_r.x);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, want end within 200000");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset = 1'b1; obs_reset = 1'b0; valid = 1'b0; value = 8'h00;

        // 1: reset state and first lock
        step(0, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'd10, 0, 0, 0, 16'd0, 8'd11);
        step(0, 0, 0, 1, 8'd11, 0, 0, 0, 16'd0, 8'd12);
        step(0, 0, 0, 1, 8'd12, 0, 0, 0, 16'd0, 8'd13);
        step(0, 0, 0, 1, 8'd13, 0, 0, 0, 16'd0, 8'd14);
        step(0, 0, 0, 1, 8'd14, 1, 0, 0, 16'd0, 8'd15);

        // 2: wrap through all-ones
        step(0, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'hF9, 0, 0, 0, 16'd0, 8'hFA);
        step(0, 0, 0, 1, 8'hFA, 0, 0, 0, 16'd0, 8'hFB);
        step(0, 0, 0, 1, 8'hFB, 0, 0, 0, 16'd0, 8'hFC);
        step(0, 0, 0, 1, 8'hFC, 0, 0, 0, 16'd0, 8'hFD);
        step(0, 0, 0, 1, 8'hFD, 1, 0, 0, 16'd0, 8'hFE);
        step(0, 0, 0, 1, 8'hFE, 1, 0, 0, 16'd0, 8'hFF);
        step(0, 0, 0, 1, 8'hFF, 1, 0, 1, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'h00, 1, 0, 0, 16'd0, 8'h01);

        // 3: mismatch, resync with an uncounted second error
        step(0, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'h1B, 0, 0, 0, 16'd0, 8'h1C);
        step(0, 0, 0, 1, 8'h1C, 0, 0, 0, 16'd0, 8'h1D);
        step(0, 0, 0, 1, 8'h1D, 0, 0, 0, 16'd0, 8'h1E);
        step(0, 0, 0, 1, 8'h1E, 0, 0, 0, 16'd0, 8'h1F);
        step(0, 0, 0, 1, 8'h1F, 1, 0, 0, 16'd0, 8'h20);
        step(0, 0, 0, 1, 8'h25, 0, 1, 0, 16'd1, 8'h26);
        step(0, 0, 0, 1, 8'h26, 0, 0, 0, 16'd1, 8'h27);
        step(0, 0, 0, 1, 8'h27, 0, 0, 0, 16'd1, 8'h28);
        step(0, 0, 0, 1, 8'h28, 0, 0, 0, 16'd1, 8'h29);
        step(0, 0, 0, 1, 8'h40, 0, 0, 0, 16'd1, 8'h41);
        step(0, 0, 0, 1, 8'h41, 0, 0, 0, 16'd1, 8'h42);
        step(0, 0, 0, 1, 8'h42, 0, 0, 0, 16'd1, 8'h43);
        step(0, 0, 0, 1, 8'h43, 0, 0, 0, 16'd1, 8'h44);
        step(0, 0, 0, 1, 8'h44, 1, 0, 0, 16'd1, 8'h45);

        // 4: walk to 0x50 locked, then obs_reset with a junk valid sample
        for (int v = 8'h45; v <= 8'h4F; v++)
            step(0, 0, 0, 1, 8'(v), 1, 0, 0, 16'd1, 8'(v + 1));
        step(0, 0, 1, 1, 8'h77, 1, 0, 0, 16'd1, 8'h00);
        step(0, 0, 0, 1, 8'h00, 1, 0, 0, 16'd1, 8'h01);
        step(0, 0, 0, 1, 8'h01, 1, 0, 0, 16'd1, 8'h02);
        step(0, 0, 0, 1, 8'h02, 1, 0, 0, 16'd1, 8'h03);

        // 6: reset with a bad sample present, then lock across valid gaps
        step(0, 1, 0, 1, 8'h99, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'h03, 0, 0, 0, 16'd0, 8'h04);
        step(0, 0, 0, 0, 8'h55, 0, 0, 0, 16'd0, 8'h04);
        step(0, 0, 0, 1, 8'h04, 0, 0, 0, 16'd0, 8'h05);
        step(0, 0, 0, 0, 8'h55, 0, 0, 0, 16'd0, 8'h05);
        step(0, 0, 0, 1, 8'h05, 0, 0, 0, 16'd0, 8'h06);
        step(0, 0, 0, 0, 8'h55, 0, 0, 0, 16'd0, 8'h06);
        step(0, 0, 0, 1, 8'h06, 0, 0, 0, 16'd0, 8'h07);
        step(0, 0, 0, 0, 8'h55, 0, 0, 0, 16'd0, 8'h07);
        step(0, 0, 0, 1, 8'h07, 1, 0, 0, 16'd0, 8'h08);
        step(0, 0, 0, 0, 8'h55, 1, 0, 0, 16'd0, 8'h08);

        // reset beats obs_reset; obs_reset in IDLE goes to ACQUIRE at 0
        step(0, 1, 1, 1, 8'h30, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 1, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00);
        step(0, 0, 0, 1, 8'h00, 0, 0, 0, 16'd0, 8'h01);
        step(0, 0, 0, 1, 8'h01, 0, 0, 0, 16'd0, 8'h02);
        step(0, 0, 0, 1, 8'h02, 0, 0, 0, 16'd0, 8'h03);
        step(0, 0, 0, 1, 8'h03, 1, 0, 0, 16'd0, 8'h04);

        // 5: two-bit error counter saturates at 3 (LOCK_LEN=1)
        step(1, 1, 0, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00);
        step(1, 0, 0, 1, 8'h05, 0, 0, 0, 16'd0, 8'h06);
        step(1, 0, 0, 1, 8'h06, 1, 0, 0, 16'd0, 8'h07);
        step(1, 0, 0, 1, 8'h10, 0, 1, 0, 16'd1, 8'h11);
        step(1, 0, 0, 1, 8'h11, 1, 0, 0, 16'd1, 8'h12);
        step(1, 0, 0, 1, 8'h20, 0, 1, 0, 16'd2, 8'h21);
        step(1, 0, 0, 1, 8'h21, 1, 0, 0, 16'd2, 8'h22);
        step(1, 0, 0, 1, 8'h30, 0, 1, 0, 16'd3, 8'h31);
        step(1, 0, 0, 1, 8'h31, 1, 0, 0, 16'd3, 8'h32);
        step(1, 0, 0, 1, 8'h40, 0, 1, 0, 16'd3, 8'h41);
        step(1, 0, 0, 1, 8'h41, 1, 0, 0, 16'd3, 8'h42);
        step(1, 0, 0, 1, 8'h50, 0, 1, 0, 16'd3, 8'h51);
        step(1, 0, 0, 1, 8'h51, 1, 0, 0, 16'd3, 8'h52);

        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            $display("FAIL drain: got %0d pending responses, want 0", sb_q.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
